input_port_ctrl: RTL and testbench

INPUT_PORT_CTRL -- requirements
Module: input_port_ctrl

---
 rtl/input_port_ctrl.sv | 178 +++++++++++++++++
 tb/tb_input_port_ctrl.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/input_port_ctrl.sv
// Router input port: flit FIFO with a route / wait-grant / forward FSM; IPC_TIMEOUT_EN adds a grant-wait timeout with packet drop.
// Latency: a header pushed in cycle 0 is in ROUTE in cycle 2 and is on ipc_flit_o in cycle 4 if granted in cycle 3.
// Backpressure: ipc_ready_o is low while the FIFO is full; ipc_ready_i low holds the FIFO head on ipc_flit_o.
module input_port_ctrl #(
    parameter int DEPTH          = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [9:0] ipc_flit_i,
    input  logic       ipc_flit_valid_i,
    output logic       ipc_ready_o,
    output logic [7:0] ipc_addr_header_o,
    output logic       ipc_nhr_write_o,
    input  logic       ipc_grant_i,
    output logic       ipc_change_order_o,
    output logic [9:0] ipc_flit_o,
    output logic       ipc_flit_valid_o,
    input  logic       ipc_ready_i,
    output logic       ipc_timeout_o
);

    localparam int AW = $clog2(DEPTH);

    // typ[0] set: flit opens a packet (header/single); typ[1] set: flit closes it (tail/single)
    typedef struct packed {
        logic [1:0] typ;
        logic [7:0] payload;
    } flit_t;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        ROUTE      = 3'd1,
        WAIT_GRANT = 3'd2,
        FORWARD    = 3'd3,
`ifdef IPC_TIMEOUT_EN
        DROP       = 3'd5,
`endif
        RELEASE    = 3'd4
    } state_t;

    state_t        state;
    state_t        state_nxt;

    flit_t         fifo_mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   fifo_cnt;
    logic          fifo_full;
    logic          fifo_empty;
    logic          push;
    logic          pop;
    flit_t         head;
    logic          head_opens;
    logic          head_closes;
    logic          addr_ld;

    assign fifo_full   = (fifo_cnt == (AW+1)'(DEPTH));
    assign fifo_empty  = (fifo_cnt == '0);
    assign push        = ipc_flit_valid_i && !fifo_full;
    assign head        = fifo_mem[rd_ptr];
    assign head_opens  = head.typ[0];
    assign head_closes = head.typ[1];

    assign ipc_ready_o = !fifo_full;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
                2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    // Storage is not reset; stale entries are masked by the empty gate on ipc_flit_o.
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= flit_t'(ipc_flit_i);
    end

    assign ipc_flit_o = fifo_empty ? 10'h000 : 10'(head);

`ifdef IPC_TIMEOUT_EN
    localparam int CW = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

    logic [CW-1:0] wait_cnt;
    logic          timeout_hit;
    logic          timeout_q;

    // This cycle's no-grant increment would bring the count to the limit.
    assign timeout_hit = (wait_cnt == CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt  <= '0;
            timeout_q <= 1'b0;
        end else begin
            if (state == ROUTE)
                wait_cnt <= '0;
            else if (state == WAIT_GRANT && !ipc_grant_i)
                wait_cnt <= wait_cnt + 1'b1;
            if (state == WAIT_GRANT && state_nxt == DROP)
                timeout_q <= 1'b1;
        end
    end

    assign ipc_timeout_o = timeout_q;
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
    assign ipc_timeout_o      = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        addr_ld   = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    if (head_opens) begin
                        state_nxt = ROUTE;
                        addr_ld   = 1'b1;
                    end else begin
                        pop = 1'b1;
                    end
                end
            end
            ROUTE: state_nxt = WAIT_GRANT;
            WAIT_GRANT: begin
                if (ipc_grant_i)
                    state_nxt = FORWARD;
`ifdef IPC_TIMEOUT_EN
                else if (timeout_hit)
                    state_nxt = DROP;
`endif
            end
            FORWARD: begin
                if (!fifo_empty && ipc_ready_i) begin
                    pop = 1'b1;
                    if (head_closes) state_nxt = RELEASE;
                end
            end
            RELEASE: state_nxt = IDLE;
`ifdef IPC_TIMEOUT_EN
            DROP: begin
                if (!fifo_empty) begin
                    pop = 1'b1;
                    if (head_closes) state_nxt = IDLE;
                end
            end
`endif
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset)        ipc_addr_header_o <= 8'h00;
        else if (addr_ld) ipc_addr_header_o <= head.payload;
    end

    assign ipc_nhr_write_o    = (state == ROUTE);
    assign ipc_change_order_o = (state == RELEASE);
    assign ipc_flit_valid_o   = (state == FORWARD) && !fifo_empty;

endmodule

// File: tb/tb_input_port_ctrl.sv
// Directed bench for input_port_ctrl: scoreboard of forwarded flits plus cycle-exact pulse and flag checks.
module tb_input_port_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [9:0] ipc_flit_i;
    logic       ipc_flit_valid_i;
    logic       ipc_ready_o;
    logic [7:0] ipc_addr_header_o;
    logic       ipc_nhr_write_o;
    logic       ipc_grant_i;
    logic       ipc_change_order_o;
    logic [9:0] ipc_flit_o;
    logic       ipc_flit_valid_o;
    logic       ipc_ready_i;
    logic       ipc_timeout_o;

    always #5 clk = ~clk;

    input_port_ctrl #(.DEPTH(4), .TIMEOUT_CYCLES(8)) dut (
        .clk                (clk),
        .reset              (reset),
        .ipc_flit_i         (ipc_flit_i),
        .ipc_flit_valid_i   (ipc_flit_valid_i),
        .ipc_ready_o        (ipc_ready_o),
        .ipc_addr_header_o  (ipc_addr_header_o),
        .ipc_nhr_write_o    (ipc_nhr_write_o),
        .ipc_grant_i        (ipc_grant_i),
        .ipc_change_order_o (ipc_change_order_o),
        .ipc_flit_o         (ipc_flit_o),
        .ipc_flit_valid_o   (ipc_flit_valid_o),
        .ipc_ready_i        (ipc_ready_i),
        .ipc_timeout_o      (ipc_timeout_o)
    );

    int         checks  = 0;
    int         errors  = 0;
    int         nhr_cnt = 0;
    int         co_cnt  = 0;
    int         out_cnt = 0;
    int         exp_nhr = 0;
    int         exp_co  = 0;
    logic [9:0] expq [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        checks++;
        assert (obs === want) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one flit until accepted; accepted flits that must reach the crossbar go on the scoreboard.
    task automatic send(input logic [9:0] f, input bit expect_out);
        bit acc;
        acc              = 1'b0;
        ipc_flit_i       = f;
        ipc_flit_valid_i = 1'b1;
        for (int i = 0; i < 50 && !acc; i++) begin
            acc = ipc_ready_o;
            tick();
        end
        ipc_flit_valid_i = 1'b0;
        chk("send_accepted", 32'(acc), 32'd1);
        if (acc && expect_out) expq.push_back(f);
    endtask

    task automatic wait_co(input string tag);
        int i;
        i = 0;
        while (!ipc_change_order_o && i < 60) begin
            tick();
            i++;
        end
        chk(tag, 32'(ipc_change_order_o), 32'd1);
        tick();
    endtask

    always @(negedge clk) begin
        if (ipc_nhr_write_o)    nhr_cnt++;
        if (ipc_change_order_o) co_cnt++;
        if (ipc_flit_valid_o && ipc_ready_i) begin
            out_cnt++;
            chk("out_expected", 32'(expq.size() != 0), 32'd1);
            if (expq.size() != 0) chk("out_flit", 32'(ipc_flit_o), 32'(expq.pop_front()));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        reset            = 1'b1;
        ipc_flit_i       = '0;
        ipc_flit_valid_i = 1'b0;
        ipc_grant_i      = 1'b0;
        ipc_ready_i      = 1'b0;
        tick();
        tick();
        chk("rst_ready",  32'(ipc_ready_o),        32'd1);
        chk("rst_valid",  32'(ipc_flit_valid_o),   32'd0);
        chk("rst_flit",   32'(ipc_flit_o),         32'h000);
        chk("rst_addr",   32'(ipc_addr_header_o),  32'h00);
        chk("rst_nhr",    32'(ipc_nhr_write_o),    32'd0);
        chk("rst_co",     32'(ipc_change_order_o), 32'd0);
        chk("rst_tmo",    32'(ipc_timeout_o),      32'd0);
        reset = 1'b0;
        tick();

        // Single flit, grant held high: exact latency of every pulse
        ipc_grant_i = 1'b1;
        ipc_ready_i = 1'b1;
        send(10'h321, 1'b1);
        exp_nhr++; exp_co++;
        chk("s_c1_nhr",   32'(ipc_nhr_write_o),    32'd0);
        tick();
        chk("s_c2_nhr",   32'(ipc_nhr_write_o),    32'd1);
        chk("s_c2_addr",  32'(ipc_addr_header_o),  32'h21);
        tick();
        chk("s_c3_valid", 32'(ipc_flit_valid_o),   32'd0);
        chk("s_c3_nhr",   32'(ipc_nhr_write_o),    32'd0);
        tick();
        chk("s_c4_valid", 32'(ipc_flit_valid_o),   32'd1);
        chk("s_c4_flit",  32'(ipc_flit_o),         32'h321);
        chk("s_c4_co",    32'(ipc_change_order_o), 32'd0);
        tick();
        chk("s_c5_co",    32'(ipc_change_order_o), 32'd1);
        chk("s_c5_valid", 32'(ipc_flit_valid_o),   32'd0);
        tick();
        chk("s_c6_co",    32'(ipc_change_order_o), 32'd0);
        tick();

        // Four-flit packet, grant in cycle 10, downstream ready toggling
        ipc_grant_i = 1'b0;
        ipc_ready_i = 1'b1;
        send(10'h112, 1'b1);
        send(10'h0A1, 1'b1);
        send(10'h0A2, 1'b1);
        send(10'h2A3, 1'b1);
        exp_nhr++; exp_co++;
        repeat (6) tick();
        chk("p4_c10_valid", 32'(ipc_flit_valid_o), 32'd0);
        ipc_grant_i = 1'b1;
        tick();
        ipc_grant_i = 1'b0;
        chk("p4_c11_valid", 32'(ipc_flit_valid_o), 32'd1);
        chk("p4_c11_flit",  32'(ipc_flit_o),       32'h112);
        for (int i = 0; i < 40 && !ipc_change_order_o; i++) begin
            tick();
            ipc_ready_i = ~ipc_ready_i;
        end
        wait_co("p4_co");
        ipc_ready_i = 1'b1;
        tick();

        // FIFO fill with downstream stalled: fifth flit held upstream
        ipc_grant_i = 1'b1;
        ipc_ready_i = 1'b0;
        send(10'h140, 1'b1);
        send(10'h041, 1'b1);
        send(10'h042, 1'b1);
        send(10'h043, 1'b1);
        exp_nhr++; exp_co++;
        chk("full_ready", 32'(ipc_ready_o),      32'd0);
        chk("full_valid", 32'(ipc_flit_valid_o), 32'd1);
        chk("full_head",  32'(ipc_flit_o),       32'h140);
        ipc_flit_i       = 10'h244;
        ipc_flit_valid_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("full_hold", 32'(ipc_ready_o), 32'd0);
        end
        ipc_ready_i = 1'b1;
        send(10'h244, 1'b1);
        wait_co("full_co");
        tick();

        // Stray body before a header is discarded in IDLE
        send(10'h055, 1'b0);
        send(10'h134, 1'b1);
        send(10'h277, 1'b1);
        exp_nhr++; exp_co++;
        for (int i = 0; i < 20 && !ipc_nhr_write_o; i++) tick();
        chk("stray_nhr",  32'(ipc_nhr_write_o),   32'd1);
        chk("stray_addr", 32'(ipc_addr_header_o), 32'h34);
        wait_co("stray_co");
        tick();

`ifdef IPC_TIMEOUT_EN
        // No grant: timeout after 8 WAIT_GRANT cycles, packet dropped silently
        ipc_grant_i = 1'b0;
        base = co_cnt;
        send(10'h1AB, 1'b0);
        send(10'h0AC, 1'b0);
        send(10'h2AD, 1'b0);
        exp_nhr++;
        repeat (7) tick();
        chk("tmo_c10", 32'(ipc_timeout_o), 32'd0);
        tick();
        chk("tmo_c11", 32'(ipc_timeout_o), 32'd1);
        repeat (3) tick();
        chk("tmo_ready",   32'(ipc_ready_o),      32'd1);
        chk("tmo_valid",   32'(ipc_flit_valid_o), 32'd0);
        chk("tmo_no_co",   32'(co_cnt - base),    32'd0);
        ipc_grant_i = 1'b1;
        send(10'h3B0, 1'b1);
        exp_nhr++; exp_co++;
        wait_co("tmo_next_co");
        chk("tmo_sticky", 32'(ipc_timeout_o), 32'd1);
        tick();
`else
        // Without the timeout option the grant wait is unbounded
        ipc_grant_i = 1'b0;
        send(10'h3CD, 1'b1);
        exp_nhr++; exp_co++;
        repeat (100) tick();
        chk("wait_valid", 32'(ipc_flit_valid_o), 32'd0);
        chk("wait_tmo",   32'(ipc_timeout_o),    32'd0);
        ipc_grant_i = 1'b1;
        wait_co("wait_co");
        tick();
`endif

        // Reset in FORWARD after two of four flits
        ipc_grant_i = 1'b1;
        ipc_ready_i = 1'b1;
        base = out_cnt;
        send(10'h156, 1'b1);
        send(10'h0D1, 1'b1);
        send(10'h0D2, 1'b1);
        send(10'h2D3, 1'b1);
        exp_nhr++;
        for (int i = 0; i < 30 && (out_cnt - base) < 2; i++) tick();
        chk("mid_two_out", 32'(out_cnt - base), 32'd2);
        base        = co_cnt;
        reset       = 1'b1;
        ipc_ready_i = 1'b0;
        tick();
        reset = 1'b0;
        chk("mid_valid", 32'(ipc_flit_valid_o),   32'd0);
        chk("mid_ready", 32'(ipc_ready_o),        32'd1);
        chk("mid_flit",  32'(ipc_flit_o),         32'h000);
        chk("mid_co",    32'(ipc_change_order_o), 32'd0);
        expq.delete();
        tick();
        chk("mid_idle_nhr", 32'(ipc_nhr_write_o), 32'd0);
        chk("mid_no_co",    32'(co_cnt - base),   32'd0);

        // Fresh packet after reset: old flits must not reappear
        ipc_ready_i = 1'b1;
        send(10'h3EE, 1'b1);
        exp_nhr++; exp_co++;
        wait_co("post_rst_co");
        tick();

        chk("end_queue_empty", 32'(expq.size()), 32'd0);
        chk("end_nhr_pulses",  32'(nhr_cnt),     32'(exp_nhr));
        chk("end_co_pulses",   32'(co_cnt),      32'(exp_co));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
